multi_cycle_main_controller: RTL and testbench

Main control FSM of the multi-cycle accumulator processor. Each cycle it reads the IR opcode, and in type-C write-back the `noOp`/`moveTo` flags returned by the ALU controller. It sequences fetch, decode, execute and write-back, and drives every datapath enable plus the `aluOp` code consumed by the ALU controller. It sits beside the ALU controller: it generates `aluOp`, and the ALU controller turns `aluOp` plus `func` into `aluOpc`, `noOp` and `moveTo`.

---
 rtl/multi_cycle_main_controller.sv | 138 +++++++++++++
 tb/tb_multi_cycle_main_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/multi_cycle_main_controller.sv
// multi_cycle_main_controller: fetch/decode/execute/write-back sequencer for the multi-cycle accumulator processor.
module multi_cycle_main_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             noOp,
  input  logic             moveTo,
  output logic [2:0]       aluOp,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic             IorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic             instDone,
  output logic [CNT_W-1:0] instCount
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LD_MEM, S_LD_WB, S_ST, S_JMP, S_BRZ, S_C_EX, S_C_WB, S_I_EX, S_I_WB
  } state_t;
  state_t r_state, w_next;
  logic [1:0] r_iop;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_iop   <= '0;
    end else begin
      r_state <= w_next;
      // ADDI/SUBI/ANDI (101/110/111) map onto aluOp 000/001/010
      if (r_state == S_DECODE) r_iop <= opcode[1:0] - 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) instCount <= '0;
    else if (instDone) instCount <= instCount + CNT_W'(1);
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE:
        case (opcode)
          3'd0:    w_next = S_LD_MEM;
          3'd1:    w_next = S_ST;
          3'd2:    w_next = S_JMP;
          3'd3:    w_next = S_BRZ;
          3'd4:    w_next = S_C_EX;
          default: w_next = S_I_EX;
        endcase
      S_LD_MEM: w_next = S_LD_WB;
      S_C_EX:   w_next = S_C_WB;
      S_I_EX:   w_next = S_I_WB;
      default:  w_next = S_FETCH;
    endcase
  end
  // Outputs are held at zero for the whole reset cycle, including FETCH strobes.
  always_comb begin
    aluOp    = 3'b000;
    pcWrite  = 1'b0;
    pcSrc    = 1'b0;
    IorD     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    irWrite  = 1'b0;
    regWrite = 1'b0;
    regDst   = 1'b0;
    memToReg = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    instDone = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          memRead = 1'b1;
          irWrite = 1'b1;
          aluSrcB = 2'b01;
          pcWrite = 1'b1;
        end
        S_LD_MEM: begin
          memRead = 1'b1;
          IorD    = 1'b1;
        end
        S_LD_WB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
          instDone = 1'b1;
        end
        S_ST: begin
          memWrite = 1'b1;
          IorD     = 1'b1;
          instDone = 1'b1;
        end
        S_JMP: begin
          pcWrite  = 1'b1;
          pcSrc    = 1'b1;
          instDone = 1'b1;
        end
        S_BRZ: begin
          pcWrite  = zero;
          pcSrc    = 1'b1;
          instDone = 1'b1;
        end
        S_C_EX: begin
          aluSrcA = 1'b1;
          aluOp   = 3'b100;
        end
        S_C_WB: begin
          aluSrcA  = 1'b1;
          aluOp    = 3'b100;
          regWrite = ~noOp;
          regDst   = moveTo;
          instDone = 1'b1;
        end
        S_I_EX: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          aluOp   = {1'b0, r_iop};
        end
        S_I_WB: begin
          aluSrcA  = 1'b1;
          aluSrcB  = 2'b10;
          aluOp    = {1'b0, r_iop};
          regWrite = 1'b1;
          instDone = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_main_controller.sv
// tb_multi_cycle_main_controller: randomized scoreboard bench with an instruction-level reference model.
module tb_multi_cycle_main_controller;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, noOp = 1'b0, moveTo = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [2:0] aluOp, aluOp4;
  logic pcWrite, pcSrc, IorD, memRead, memWrite, irWrite, regWrite, regDst, memToReg, aluSrcA, instDone;
  logic pcWrite4, pcSrc4, IorD4, memRead4, memWrite4, irWrite4, regWrite4, regDst4, memToReg4, aluSrcA4, instDone4;
  logic [1:0] aluSrcB, aluSrcB4;
  logic [15:0] instCount;
  logic [3:0] instCount4;
  int tests = 0, fails = 0, cnt = 0;
  logic chk = 1'b0;
  typedef struct {logic [15:0] ctl; int cnt; logic chk;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  multi_cycle_main_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .noOp(noOp), .moveTo(moveTo),
    .aluOp(aluOp), .pcWrite(pcWrite), .pcSrc(pcSrc), .IorD(IorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite), .regDst(regDst),
    .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .instDone(instDone),
    .instCount(instCount)
  );
  multi_cycle_main_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .noOp(noOp), .moveTo(moveTo),
    .aluOp(aluOp4), .pcWrite(pcWrite4), .pcSrc(pcSrc4), .IorD(IorD4), .memRead(memRead4),
    .memWrite(memWrite4), .irWrite(irWrite4), .regWrite(regWrite4), .regDst(regDst4),
    .memToReg(memToReg4), .aluSrcA(aluSrcA4), .aluSrcB(aluSrcB4), .instDone(instDone4),
    .instCount(instCount4)
  );
  wire [15:0] w_ctl  = {aluOp, pcWrite, pcSrc, IorD, memRead, memWrite, irWrite, regWrite, regDst,
                        memToReg, aluSrcA, aluSrcB, instDone};
  wire [15:0] w_ctl4 = {aluOp4, pcWrite4, pcSrc4, IorD4, memRead4, memWrite4, irWrite4, regWrite4,
                        regDst4, memToReg4, aluSrcA4, aluSrcB4, instDone4};
  function automatic logic [15:0] mk(input logic [2:0] a, input logic pw, ps, id, mr, mw, iw, rw, rd, mt, sa,
                                     input logic [1:0] sb, input logic dn);
    return {a, pw, ps, id, mr, mw, iw, rw, rd, mt, sa, sb, dn};
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic logic [2:0] r3();
    return 3'($urandom);
  endfunction
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (w_ctl !== e.ctl) begin
        fails++;
        $display("FAIL ctl t=%0t got %h exp %h", $time, w_ctl, e.ctl);
      end
      tests++;
      if (w_ctl4 !== e.ctl) begin
        fails++;
        $display("FAIL ctl4 t=%0t got %h exp %h", $time, w_ctl4, e.ctl);
      end
      if (e.chk) begin
        tests++;
        if (instCount !== e.cnt[15:0]) begin
          fails++;
          $display("FAIL instCount t=%0t got %0d exp %0d", $time, instCount, e.cnt[15:0]);
        end
        tests++;
        if (instCount4 !== e.cnt[3:0]) begin
          fails++;
          $display("FAIL instCount4 t=%0t got %0d exp %0d", $time, instCount4, e.cnt[3:0]);
        end
      end
    end
  end
  task automatic step(input logic r, input logic [2:0] op, input logic z, n, m, input logic [15:0] ctl);
    rst = r; opcode = op; zero = z; noOp = n; moveTo = m;
    q.push_back('{ctl, cnt, chk});
    if (r) begin
      cnt = 0;
      chk = 1'b1;
    end else if (ctl[0]) cnt++;
    @(posedge clk); #1;
  endtask
  task automatic fetch_decode(input logic [2:0] op);
    step(0, r3(), rb(), rb(), rb(), mk(3'b000, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 0));
    step(0, op, rb(), rb(), rb(), 16'h0000);
  endtask
  task automatic instr(input logic [2:0] op, input logic z, n, m);
    logic [2:0] a;
    fetch_decode(op);
    case (op)
      3'd0: begin
        step(0, r3(), rb(), rb(), rb(), mk(3'b000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        step(0, r3(), rb(), rb(), rb(), mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 1));
      end
      3'd1: step(0, r3(), rb(), rb(), rb(), mk(3'b000, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 1));
      3'd2: step(0, r3(), rb(), rb(), rb(), mk(3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
      3'd3: step(0, r3(), z, rb(), rb(), mk(3'b000, z, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
      3'd4: begin
        step(0, r3(), rb(), rb(), rb(), mk(3'b100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
        step(0, r3(), rb(), n, m, mk(3'b100, 0, 0, 0, 0, 0, 0, ~n, m, 0, 1, 2'b00, 1));
      end
      default: begin
        a = op - 3'd5;
        step(0, r3(), rb(), rb(), rb(), mk(a, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0));
        step(0, r3(), rb(), rb(), rb(), mk(a, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b10, 1));
      end
    endcase
  endtask
  initial begin
    @(posedge clk); #1;
    step(1, r3(), rb(), rb(), rb(), 16'h0000);
    step(1, r3(), rb(), rb(), rb(), 16'h0000);
    instr(3'd0, 0, 0, 0);
    instr(3'd1, 0, 0, 0);
    instr(3'd2, 0, 0, 0);
    tests++;
    if (instCount !== 16'd3) begin
      fails++;
      $display("FAIL count_after_10 got %0d exp 3", instCount);
    end
    instr(3'd3, 1, 0, 0);
    instr(3'd3, 0, 0, 0);
    instr(3'd4, 0, 0, 0);
    instr(3'd4, 0, 0, 1);
    instr(3'd4, 0, 1, 0);
    instr(3'd4, 0, 1, 1);
    instr(3'd5, 0, 0, 0);
    instr(3'd6, 0, 0, 0);
    instr(3'd7, 0, 0, 0);
    // abandon a LOAD while in LD_MEM; the reset edge lands where LD_WB would retire
    fetch_decode(3'd0);
    step(0, r3(), rb(), rb(), rb(), mk(3'b000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    step(1, r3(), rb(), rb(), rb(), 16'h0000);
    instr(3'd1, 0, 0, 0);
    step(1, r3(), rb(), rb(), rb(), 16'h0000);
    for (int i = 0; i < 17; i++) instr(3'd1, 0, 0, 0);
    tests++;
    if (instCount4 !== 4'd1) begin
      fails++;
      $display("FAIL wrap17 got %0d exp 1", instCount4);
    end
    for (int i = 0; i < 40; i++) instr(r3(), rb(), rb(), rb());
    @(negedge clk); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d entries exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
